vga_layer_mixer: RTL and testbench

//  Parametrised priority compositor between the VGA timing generator and the pins.

---
 rtl/vga_layer_mixer_pkg.sv | 27 ++
 rtl/vga_layer_mixer_if.sv | 32 +++
 rtl/vga_layer_mixer_blink_gen.sv | 50 +++++
 rtl/vga_layer_mixer.sv | 103 ++++++++++
 tb/tb_vga_layer_mixer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/vga_layer_mixer_pkg.sv
// Shared definitions for the VGA layer mixer: blink mode encodings, colour
// defaults and the per-layer blink gate helper.
package vga_layer_mixer_pkg;

    typedef enum logic [1:0] {
        BLINK_STEADY = 2'b00,
        BLINK_A      = 2'b01,
        BLINK_B      = 2'b10,
        BLINK_NA     = 2'b11
    } blink_mode_e;

    localparam int RGB_W_DEF = 12;
    localparam logic [RGB_W_DEF-1:0] BLACK = 12'h000;

    function automatic logic blink_gate(input blink_mode_e mode, input logic a, input logic b);
        logic g;
        case (mode)
            BLINK_STEADY: g = 1'b1;
            BLINK_A:      g = a;
            BLINK_B:      g = b;
            BLINK_NA:     g = ~a;
            default:      g = 1'b1;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/vga_layer_mixer_if.sv
// Pixel-side bundle between the timing generator / layer sources (master)
// and the layer mixer (slave).
interface vga_layer_mixer_if #(
    parameter int NUM_LAYERS = 6,
    parameter int RGB_W      = 12
);
    localparam int AL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                        pixel_tick;
    logic                        video_on;
    logic                        frame_start;
    logic [NUM_LAYERS-1:0]       layer_on;
    logic [NUM_LAYERS*RGB_W-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]       layer_en;
    logic [2*NUM_LAYERS-1:0]     blink_mode;
    logic [RGB_W-1:0]            RGB;
    logic [AL_W-1:0]             active_layer;
    logic                        layer_hit;
    logic                        blink_a;
    logic                        blink_b;

    modport master (
        output pixel_tick, video_on, frame_start, layer_on, layer_rgb, layer_en, blink_mode,
        input  RGB, active_layer, layer_hit, blink_a, blink_b
    );

    modport slave (
        input  pixel_tick, video_on, frame_start, layer_on, layer_rgb, layer_en, blink_mode,
        output RGB, active_layer, layer_hit, blink_a, blink_b
    );

endinterface

// File: rtl/vga_layer_mixer_blink_gen.sv
// Free-running blink divider: raw phase toggles every DIV+1 clocks, and the
// exported phase only follows it on frame_start so a frame never tears.
module blink_gen #(
    parameter int DIV   = 16666666,
    parameter int CNT_W = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic frame_start,
    output logic raw,
    output logic phase
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw_q, raw_d;
    logic             phase_q, phase_d;

    // next-state: wrap/toggle at terminal count; latch pre-toggle raw on frame_start
    always_comb begin
        if (cnt_q == CNT_W'(DIV)) begin
            cnt_d = {CNT_W{1'b0}};
            raw_d = ~raw_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            raw_d = raw_q;
        end
        if (frame_start) begin
            phase_d = raw_q;
        end else begin
            phase_d = phase_q;
        end
    end

    // state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= {CNT_W{1'b0}};
            raw_q   <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            raw_q   <= raw_d;
            phase_q <= phase_d;
        end
    end

    assign raw   = raw_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_layer_mixer.sv
// Priority compositor: picks the highest-priority visible layer (index 0 wins)
// and registers the resulting pixel on each pixel_tick.
module vga_layer_mixer
    import vga_layer_mixer_pkg::*;
#(
    parameter int               NUM_LAYERS  = 6,
    parameter int               RGB_W       = RGB_W_DEF,
    parameter int               CNT_W       = 25,
    parameter int               BLINK_A_DIV = 16666666,
    parameter int               BLINK_B_DIV = 24999999,
    parameter logic [RGB_W-1:0] BG_COLOR    = BLACK
) (
    input  logic               clock,
    input  logic               reset,
    vga_layer_mixer_if.slave   bus
);

    localparam int AL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                  blink_a_s, blink_b_s;
    logic                  raw_a_unused_s, raw_b_unused_s;
    logic [NUM_LAYERS-1:0] vis_s;
    logic [AL_W-1:0]       sel_s, next_sel_s;
    logic [RGB_W-1:0]      color_s, next_rgb_s;
    logic                  hit_s, next_hit_s;

    logic [RGB_W-1:0]      rgb_q, rgb_d;
    logic [AL_W-1:0]       active_q, active_d;
    logic                  hit_q, hit_d;

    blink_gen #(.DIV(BLINK_A_DIV), .CNT_W(CNT_W)) u_blink_a (
        .clock       (clock),
        .reset       (reset),
        .frame_start (bus.frame_start),
        .raw         (raw_a_unused_s),
        .phase       (blink_a_s)
    );

    blink_gen #(.DIV(BLINK_B_DIV), .CNT_W(CNT_W)) u_blink_b (
        .clock       (clock),
        .reset       (reset),
        .frame_start (bus.frame_start),
        .raw         (raw_b_unused_s),
        .phase       (blink_b_s)
    );

    // visibility, priority select (scanning downwards so index 0 overrides) and output next-state
    always_comb begin
        vis_s   = {NUM_LAYERS{1'b0}};
        sel_s   = {AL_W{1'b0}};
        color_s = BG_COLOR;
        hit_s   = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            vis_s[i] = bus.layer_on[i] & bus.layer_en[i]
                     & blink_gate(blink_mode_e'(bus.blink_mode[2*i +: 2]), blink_a_s, blink_b_s);
        end
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            sel_s   = vis_s[i] ? AL_W'(i) : sel_s;
            color_s = vis_s[i] ? bus.layer_rgb[i*RGB_W +: RGB_W] : color_s;
            hit_s   = hit_s | vis_s[i];
        end

        if (bus.video_on) begin
            next_rgb_s = color_s;
            next_sel_s = sel_s;
            next_hit_s = hit_s;
        end else begin
            next_rgb_s = {RGB_W{1'b0}};
            next_sel_s = {AL_W{1'b0}};
            next_hit_s = 1'b0;
        end

        if (bus.pixel_tick) begin
            rgb_d    = next_rgb_s;
            active_d = next_sel_s;
            hit_d    = next_hit_s;
        end else begin
            rgb_d    = rgb_q;
            active_d = active_q;
            hit_d    = hit_q;
        end
    end

    // pixel output register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_q    <= {RGB_W{1'b0}};
            active_q <= {AL_W{1'b0}};
            hit_q    <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            active_q <= active_d;
            hit_q    <= hit_d;
        end
    end

    assign bus.RGB          = rgb_q;
    assign bus.active_layer = active_q;
    assign bus.layer_hit    = hit_q;
    assign bus.blink_a      = blink_a_s;
    assign bus.blink_b      = blink_b_s;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer with DIV_A=3, DIV_B=5, four layers and a
// pixel tick on every fourth clock.
module tb_vga_layer_mixer;

    localparam int NL = 4;
    localparam int RW = 12;
    localparam logic [RW-1:0] BG = 12'h123;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   k = 0;        // clock edges since reset release
    int   kc;
    int   checks = 0;
    int   errors = 0;

    vga_layer_mixer_if #(.NUM_LAYERS(NL), .RGB_W(RW)) bus ();

    vga_layer_mixer #(
        .NUM_LAYERS(NL), .RGB_W(RW), .CNT_W(25),
        .BLINK_A_DIV(3), .BLINK_B_DIV(5), .BG_COLOR(BG)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic raw_a_at(input int n);
        return logic'((n / 4) % 2);
    endfunction

    function automatic logic raw_b_at(input int n);
        return logic'((n / 6) % 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        bus.pixel_tick = ((k + 1) % 4 == 0);
        @(posedge clock);
        k++;
        #1;
    endtask

    task automatic to_tick();
        do cycle(); while (k % 4 != 0);
    endtask

    task automatic pulse_frame();
        kc = k;
        bus.frame_start = 1'b1;
        cycle();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_raw_a(input logic v);
        while (raw_a_at(k) != v) cycle();
    endtask

    initial begin
        bus.pixel_tick  = 1'b0;
        bus.video_on    = 1'b0;
        bus.frame_start = 1'b0;
        bus.layer_on    = 4'b0000;
        bus.layer_en    = 4'b1111;
        bus.blink_mode  = 8'h00;
        bus.layer_rgb   = {12'h555, 12'h0F0, 12'hF00, 12'h00F};

        @(posedge clock);
        @(posedge clock);
        #1;
        chk("reset_rgb", 32'(bus.RGB), 32'h0);
        chk("reset_hit", 32'(bus.layer_hit), 32'h0);
        chk("reset_active", 32'(bus.active_layer), 32'h0);
        reset = 1'b0;
        k = 0;

        for (int i = 0; i < 40; i++) cycle();
        chk("hold_blink_a", 32'(bus.blink_a), 32'h0);
        chk("hold_blink_b", 32'(bus.blink_b), 32'h0);

        // priority between layers 1 and 2, not visible before the tick
        bus.video_on = 1'b1;
        bus.layer_on = 4'b0110;
        cycle(); cycle(); cycle();
        chk("pre_tick_rgb", 32'(bus.RGB), 32'h0);
        cycle();
        chk("prio_rgb", 32'(bus.RGB), 32'hF00);
        chk("prio_active", 32'(bus.active_layer), 32'h1);
        chk("prio_hit", 32'(bus.layer_hit), 32'h1);

        bus.video_on = 1'b0;
        bus.layer_on = 4'b1111;
        to_tick();
        chk("blank_rgb", 32'(bus.RGB), 32'h0);
        chk("blank_hit", 32'(bus.layer_hit), 32'h0);
        chk("blank_active", 32'(bus.active_layer), 32'h0);

        bus.video_on = 1'b1;
        bus.layer_on = 4'b0000;
        to_tick();
        chk("bg_rgb", 32'(bus.RGB), 32'(BG));
        chk("bg_hit", 32'(bus.layer_hit), 32'h0);

        bus.layer_on = 4'b1000;
        to_tick();
        chk("l3_rgb", 32'(bus.RGB), 32'h555);
        chk("l3_active", 32'(bus.active_layer), 32'h3);

        // layer0 on A, layer1 on ~A
        bus.layer_on   = 4'b0011;
        bus.blink_mode = 8'b00_00_11_01;
        wait_raw_a(1'b1);
        pulse_frame();
        chk("fs1_blink_a", 32'(bus.blink_a), 32'h1);
        chk("fs1_blink_b", 32'(bus.blink_b), 32'(raw_b_at(kc)));
        to_tick();
        chk("fs1_rgb", 32'(bus.RGB), 32'h00F);
        chk("fs1_active", 32'(bus.active_layer), 32'h0);
        chk("fs1_hit", 32'(bus.layer_hit), 32'h1);

        wait_raw_a(1'b0);
        pulse_frame();
        chk("fs2_blink_a", 32'(bus.blink_a), 32'h0);
        chk("fs2_blink_b", 32'(bus.blink_b), 32'(raw_b_at(kc)));
        to_tick();
        chk("fs2_rgb", 32'(bus.RGB), 32'hF00);
        chk("fs2_active", 32'(bus.active_layer), 32'h1);

        // frame_start coinciding with the terminal count captures the pre-toggle value
        wait_raw_a(1'b1);
        pulse_frame();
        chk("fs3_blink_a", 32'(bus.blink_a), 32'h1);
        while (k % 8 != 3) cycle();
        pulse_frame();
        chk("tc_blink_a", 32'(bus.blink_a), 32'h0);
        pulse_frame();
        chk("tc_next_blink_a", 32'(bus.blink_a), 32'h1);

        // disabled layer0 yields to layer1
        bus.blink_mode = 8'h00;
        bus.layer_en   = 4'b1110;
        to_tick();
        chk("en_rgb", 32'(bus.RGB), 32'hF00);
        chk("en_active", 32'(bus.active_layer), 32'h1);

        bus.layer_en = 4'b1111;
        bus.layer_on = 4'b1100;
        to_tick();
        chk("l2_rgb", 32'(bus.RGB), 32'h0F0);
        chk("l2_active", 32'(bus.active_layer), 32'h2);

        // mid-line asynchronous reset
        bus.layer_on = 4'b0001;
        while (raw_b_at(k) != 1'b1) cycle();
        pulse_frame();
        chk("pre_rst_blink_b", 32'(bus.blink_b), 32'h1);
        to_tick();
        chk("pre_rst_rgb", 32'(bus.RGB), 32'h00F);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_rgb", 32'(bus.RGB), 32'h0);
        chk("rst_hit", 32'(bus.layer_hit), 32'h0);
        chk("rst_blink_b", 32'(bus.blink_b), 32'h0);
        chk("rst_blink_a", 32'(bus.blink_a), 32'h0);
        #2;
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 9; i++) cycle();
        chk("post_rst_blink_a", 32'(bus.blink_a), 32'h0);
        pulse_frame();
        chk("post_rst_fs_blink_a", 32'(bus.blink_a), 32'(raw_a_at(kc)));
        chk("post_rst_fs_blink_b", 32'(bus.blink_b), 32'(raw_b_at(kc)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
